// File: rtl/systolic_tile_sequencer.sv
// Sequences one 4x4 tile through a 4x4 systolic array: buffer A/B rows, clear, skewed feed, drain, capture.
// Optional macro TILE_ACC_EN accumulates captured results across K-tiles until the tile flagged ld_last.

// Picks element (cnt - LANE) of a 4-element operand vector, or 0 outside the skew window.
module sts_lane_sel #(
  parameter int LANE = 0
) (
  input  logic             en,
  input  logic [2:0]       cnt,
  input  logic [3:0][15:0] vec,
  output logic [15:0]      val
);
  logic [3:0] d;
  assign d   = {1'b0, cnt} - 4'(LANE);
  assign val = (en && d < 4'd4) ? vec[d[1:0]] : '0;
endmodule

module systolic_tile_sequencer #(
  parameter int LAT = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [63:0]  ld_a_row,
  input  logic [63:0]  ld_b_row,
  input  logic         ld_last,
  output logic [63:0]  arr_west,
  output logic [63:0]  arr_north,
  output logic         arr_rst,
  input  logic [255:0] arr_out,
  output logic [255:0] res_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy
);
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, FEED, DRAIN, HOLD} state_t;

  state_t                state, state_nxt;
  logic [1:0]            rcnt, rcnt_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [3:0][3:0][15:0] a_buf, b_buf, b_col;
  logic [3:0][15:0]      west_nxt, north_nxt;
  logic [15:0][15:0]     res_cap;
  logic                  ld_fire, capture, feed_nxt;

  assign ld_ready  = !rst && (state == IDLE || state == LOAD);
  assign ld_fire   = ld_valid && ld_ready;
  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign capture   = (state == DRAIN) && (cnt == CW'(LAT));
  assign feed_nxt  = (state_nxt == FEED);

`ifdef TILE_ACC_EN
  logic              last_q, first_q;
  logic [15:0][15:0] res_v, arr_v;
  assign res_v = res_data;
  assign arr_v = arr_out;
  always_comb begin
    res_cap = '0;
    for (int p = 0; p < 16; p++) res_cap[p] = (first_q ? 16'd0 : res_v[p]) + arr_v[p];
  end
`else
  logic unused_ld_last;
  assign unused_ld_last = ld_last;
  assign res_cap        = arr_out;
`endif

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    cnt_nxt   = cnt;
    case (state)
      IDLE, LOAD: if (ld_fire) begin
        rcnt_nxt  = rcnt + 2'd1;  // wraps to 0 after beat 3
        state_nxt = (rcnt == 2'd3) ? CLEAR : LOAD;
      end
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = FEED;
      end
      FEED: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(6)) state_nxt = DRAIN;
      end
      DRAIN: begin
        cnt_nxt = cnt + CW'(1);
`ifdef TILE_ACC_EN
        if (capture) state_nxt = last_q ? HOLD : IDLE;
`else
        if (capture) state_nxt = HOLD;
`endif
      end
      HOLD: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // B columns so that both west and north lanes use the same selector.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    for (genvar k = 0; k < 4; k++) begin : g_col
      assign b_col[i][k] = b_buf[k][i];
    end
    sts_lane_sel #(.LANE(i)) u_west (
      .en(feed_nxt), .cnt(cnt_nxt[2:0]), .vec(a_buf[i]), .val(west_nxt[i])
    );
    sts_lane_sel #(.LANE(i)) u_north (
      .en(feed_nxt), .cnt(cnt_nxt[2:0]), .vec(b_col[i]), .val(north_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      a_buf[rcnt] <= ld_a_row;
      b_buf[rcnt] <= ld_b_row;
    end
  end

  // Array drive is computed from next state so the register holds it for the cycle the array samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rcnt      <= '0;
      cnt       <= '0;
      arr_west  <= '0;
      arr_north <= '0;
      arr_rst   <= 1'b1;
      res_data  <= '0;
`ifdef TILE_ACC_EN
      last_q    <= 1'b0;
      first_q   <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      rcnt      <= rcnt_nxt;
      cnt       <= cnt_nxt;
      arr_west  <= west_nxt;
      arr_north <= north_nxt;
      arr_rst   <= (state_nxt == CLEAR);
      if (capture) res_data <= res_cap;
`ifdef TILE_ACC_EN
      if (ld_fire && rcnt == 2'd3) last_q <= ld_last;
      if (res_valid && res_ready) first_q <= 1'b1;
      else if (capture)           first_q <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: behavioural 4x4 MAC array, directed tiles, result scoreboard.
module tb_systolic_tile_sequencer;
  localparam int LAT = 10;
  typedef logic [3:0][3:0][15:0] tile_t;

  logic         clk = 1'b0, rst = 1'b1;
  logic         ld_valid = 1'b0, ld_last = 1'b0, res_ready = 1'b1;
  logic [63:0]  ld_a_row = '0, ld_b_row = '0;
  logic         ld_ready, arr_rst, res_valid, busy;
  logic [63:0]  arr_west, arr_north;
  logic [255:0] arr_out, res_data;

  int           checks = 0, errors = 0, cyc = 0, e_last = 0;
  logic [255:0] exp_q[$];
  logic         prev_v = 1'b0;

  systolic_tile_sequencer #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_a_row(ld_a_row), .ld_b_row(ld_b_row), .ld_last(ld_last),
    .arr_west(arr_west), .arr_north(arr_north), .arr_rst(arr_rst),
    .arr_out(arr_out), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output-stationary array: A moves east, B moves south, each PE accumulates a*b mod 2^16.
  logic [15:0] acc[4][4], ah[4][4], bv[4][4];
  always @(posedge clk) begin : array_model
    logic [15:0] ai, bi;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) ai = arr_west[16*r +: 16];
        else        ai = ah[r][c-1];
        if (r == 0) bi = arr_north[16*c +: 16];
        else        bi = bv[r-1][c];
        if (arr_rst) begin
          acc[r][c] <= '0; ah[r][c] <= '0; bv[r][c] <= '0;
        end else begin
          acc[r][c] <= acc[r][c] + ai * bi;
          ah[r][c]  <= ai;
          bv[r][c]  <= bi;
        end
      end
    end
  end

  always_comb begin
    arr_out = '0;
    for (int p = 0; p < 16; p++) arr_out[255-16*p -: 16] = acc[p/4][p%4];
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] lanes_all(input logic [15:0] v);
    logic [255:0] r;
    for (int p = 0; p < 16; p++) r[16*p +: 16] = v;
    return r;
  endfunction

  function automatic tile_t tile_all(input logic [15:0] v);
    tile_t t;
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) t[r][k] = v;
    return t;
  endfunction

  // Monitor: result-valid latency on each rise, scoreboard compare on each transfer.
  always @(negedge clk) begin
    if (res_valid && !prev_v) chk("res_valid_latency", 256'(cyc - e_last), 256'(LAT + 2));
    prev_v = res_valid;
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 256'(1), 256'(0));
      else chk("res_data", res_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile(input tile_t a, input tile_t b, input logic last, input bit gap);
    for (int r = 0; r < 4; r++) begin
      if (gap && r == 2) begin
        ld_valid = 1'b0;
        step();
      end
      ld_valid = 1'b1; ld_a_row = a[r]; ld_b_row = b[r]; ld_last = last;
      @(posedge clk);
      chk("ld_ready_beat", 256'(ld_ready), 256'(1));
      #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    e_last = cyc;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      step();
      n++;
    end
    chk("tile_done", 256'(busy), 256'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    tile_t        a, b, ident;
    logic [255:0] e;
    logic [63:0]  ew, en;
    int           n, nv;

    ident = '0;
    for (int i = 0; i < 4; i++) ident[i][i] = 16'd1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ld_ready", 256'(ld_ready), 256'(0));
    chk("rst_res_valid", 256'(res_valid), 256'(0));
    chk("rst_res_data", res_data, 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_arr_lanes", 256'({arr_west, arr_north}), 256'(0));
    chk("rst_arr_rst", 256'(arr_rst), 256'(1));
    rst = 1'b0;
    step();
    chk("idle_ld_ready", 256'(ld_ready), 256'(1));
    chk("idle_arr_rst", 256'(arr_rst), 256'(0));

    // Identity: result equals B, PE p = p+1
    for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) b[r][j] = 16'(4*r + j + 1);
    for (int p = 0; p < 16; p++) e[255-16*p -: 16] = 16'(p + 1);
    exp_q.push_back(e);
    load_tile(ident, b, 1'b1, 1'b0);
    wait_idle(40);

    // Skew: A all 2, B all 3, load with a gap; every lane = 4*6 = 24
    exp_q.push_back(lanes_all(16'd24));
    load_tile(tile_all(16'd2), tile_all(16'd3), 1'b1, 1'b1);
    chk("clear_arr_rst", 256'(arr_rst), 256'(1));
    chk("clear_lanes", 256'({arr_west, arr_north}), 256'(0));
    for (int m = 0; m < 7; m++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        ew[16*i +: 16] = (m >= i && m - i <= 3) ? 16'd2 : 16'd0;
        en[16*i +: 16] = (m >= i && m - i <= 3) ? 16'd3 : 16'd0;
      end
      chk("feed_west", 256'(arr_west), 256'(ew));
      chk("feed_north", 256'(arr_north), 256'(en));
    end
    step();
    chk("drain_lanes", 256'({arr_west, arr_north}), 256'(0));
    wait_idle(40);

    // Backpressure: 2*I x B, PE p = 2(p+1), held 20 cycles
    res_ready = 1'b0;
    for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) b[r][j] = 16'(4*r + j + 1);
    for (int p = 0; p < 16; p++) e[255-16*p -: 16] = 16'(2*(p + 1));
    exp_q.push_back(e);
    a = '0;
    for (int i = 0; i < 4; i++) a[i][i] = 16'd2;
    load_tile(a, b, 1'b1, 1'b0);
    n = 0;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
    chk("bp_valid_rise", 256'(res_valid), 256'(1));
    ld_valid = 1'b1; ld_a_row = '1; ld_b_row = '1;
    for (int k = 0; k < 20; k++) begin
      chk("bp_valid_held", 256'(res_valid), 256'(1));
      chk("bp_ld_ready", 256'(ld_ready), 256'(0));
      chk("bp_data_stable", res_data, e);
      step();
    end
    ld_valid = 1'b0;
    res_ready = 1'b1;
    step();
    chk("bp_after_busy", 256'(busy), 256'(0));
    chk("bp_after_ld_ready", 256'(ld_ready), 256'(1));
    chk("bp_after_valid", 256'(res_valid), 256'(0));

    // Wrap: 4 * 0x10000 mod 2^16 = 0
    exp_q.push_back(lanes_all(16'h0000));
    load_tile(tile_all(16'h0100), tile_all(16'h0100), 1'b1, 1'b0);
    wait_idle(40);

    // Reset at FEED cnt=3 discards the tile
    load_tile(tile_all(16'd1), tile_all(16'd1), 1'b1, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_arr_rst", 256'(arr_rst), 256'(1));
    chk("midrst_ld_ready", 256'(ld_ready), 256'(0));
    chk("midrst_res_valid", 256'(res_valid), 256'(0));
    rst = 1'b0;
    nv = 0;
    repeat (LAT + 6) begin
      step();
      if (res_valid) nv++;
    end
    chk("midrst_no_result", 256'(nv), 256'(0));
    for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) b[r][j] = 16'(4*r + j + 1);
    for (int p = 0; p < 16; p++) e[255-16*p -: 16] = 16'(p + 1);
    exp_q.push_back(e);
    load_tile(ident, b, 1'b1, 1'b0);
    wait_idle(40);

    // K-tile pair: A=I, B all 5, ld_last 0 then 1
`ifdef TILE_ACC_EN
    exp_q.push_back(lanes_all(16'd10));
`else
    exp_q.push_back(lanes_all(16'd5));
    exp_q.push_back(lanes_all(16'd5));
`endif
    load_tile(ident, tile_all(16'd5), 1'b0, 1'b0);
    wait_idle(40);
    load_tile(ident, tile_all(16'd5), 1'b1, 1'b0);
    wait_idle(40);

    step();
    chk("results_drained", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
